kmean_rx_loader: RTL and testbench
==================================

KMEAN_RX_LOADER -- requirements
Module: kmean_rx_loader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 24, width of each stream word.
- MAX_PIX, 100, pixel buffer depth.
- ADDR_W, $clog2(MAX_PIX) = 7, pixel address and size-field width.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- clk input 1: rising-edge clock.
- reset input 1: reset, synchronous, active-high.
- sin input DATA_W: stream word from host.
- sin_valid input 1: sin holds a word this cycle.
- compute_done input 1: one-cycle pulse from the clustering core.
- cfg_k output 5: cluster count, 1..16.
- cfg_size output ADDR_W: pixel count.
- mem_we output 1: pixel buffer write enable.
- mem_addr output ADDR_W: pixel buffer write address.
- mem_wdata output DATA_W: pixel word, RGB 8:8:8.
- load_done output 1: one-cycle pulse, image fully stored.
- busy output 1: high in any state except IDLE.
- strb output 1: one-cycle pulse to host, result ready.
- cfg_err output 1: last config word rejected.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, COMPUTE and DONE, and all outputs SHALL be registered.
REQ-004 In IDLE, the first cycle with sin_valid=1 SHALL be treated as the config word.
REQ-005 Config layout SHALL be: sin[ADDR_W+3:ADDR_W] = K field, sin[ADDR_W-1:0] = size, and bits above ADDR_W+3 SHALL be ignored.
REQ-006 K field decode SHALL be: 4'h0 means 16 clusters; any other value v means v clusters; cfg_k SHALL be 5 bits wide to hold 16.
REQ-007 If size==0, size>MAX_PIX, or the K field equals 1, the config SHALL be rejected:
- cfg_err=1 on the next cycle;
- state stays IDLE;
- cfg_k and cfg_size are unchanged.
REQ-008 If the config is accepted:
- cfg_k and cfg_size load on the next cycle;
- cfg_err clears to 0;
- the address counter clears to 0;
- state goes to LOAD.
REQ-009 In LOAD, each sin_valid=1 cycle SHALL store one pixel. On the next cycle: mem_we=1, mem_addr=counter, mem_wdata=sin, and the counter increments.
REQ-010 In LOAD, cycles with sin_valid=0 SHALL produce mem_we=0 and leave the counter unchanged; gaps of any length are legal.
REQ-011 When the pixel at address cfg_size-1 is accepted, the FSM SHALL go to COMPUTE, and load_done SHALL pulse in the same cycle that the final mem_we is high.
REQ-012 The counter SHALL never exceed cfg_size-1 and SHALL never wrap.
REQ-013 In COMPUTE, sin and sin_valid SHALL be ignored (no writes). On compute_done=1 the FSM SHALL go to DONE.
REQ-014 In DONE, strb SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; the sin word in the DONE cycle is ignored.
REQ-015 A compute_done pulse received outside COMPUTE SHALL be ignored.
REQ-016 cfg_k and cfg_size SHALL hold their values from acceptance until the next accepted config, including across COMPUTE, DONE and IDLE.
REQ-017 busy SHALL be 1 in LOAD, COMPUTE and DONE, and 0 in IDLE.

Reset
REQ-018 On a cycle with reset=1, state SHALL become IDLE and all of the following SHALL be 0: cfg_k, cfg_size, counter, mem_we, mem_addr, mem_wdata, load_done, busy, strb, cfg_err.
REQ-019 Reset SHALL override sin_valid and compute_done in the same cycle.
REQ-020 Reset mid-LOAD SHALL abort the load: no further writes, and the next valid word is parsed as a config word.

Verification
REQ-021 Basic load: config 0x00_0064 (K field 0, size 100), then 100 consecutive valid pixels -> cfg_k=16, cfg_size=100; 100 writes to addresses 0..99 in order, data matching; load_done coincides with the address-99 write; busy=1.
REQ-022 Gapped load: config K=3, size=4; pixels with sin_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0..3; load_done on the 4th write; a further valid word in COMPUTE causes no write.
REQ-023 Config rejects: size=0; size=101; K field=1 -> cfg_err=1 each time, state IDLE, busy=0, no writes; a following valid config (K=2, size=5) clears cfg_err and enters LOAD.
REQ-024 Completion: after load, compute_done held 0 for 10 cycles, then pulsed -> strb=1 for exactly one cycle, busy=0 the cycle after; a stray compute_done in IDLE produces no strb.
REQ-025 Reset mid-load: after 50 of 100 pixels, reset=1 for 1 cycle -> all outputs 0; next valid word is parsed as config; a new 3-pixel load writes addresses 0..2.

Source files
------------

// File: rtl/kmean_rx_loader.sv
// Receives a config word then a pixel stream from the host, fills the pixel buffer,
// and hands off to the clustering core, strobing the host once the result is ready.
//
// state   | meaning
// IDLE    | waiting for a config word on the stream
// LOAD    | storing pixels until cfg_size have been written
// COMPUTE | clustering core running, stream ignored
// DONE    | one-cycle strb to host, then back to IDLE
module kmean_rx_loader #(
    parameter int DATA_W  = 24,
    parameter int MAX_PIX = 100,
    parameter int ADDR_W  = $clog2(MAX_PIX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sin,
    input  logic              sin_valid,
    input  logic              compute_done,
    output logic [4:0]        cfg_k,
    output logic [ADDR_W-1:0] cfg_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              load_done,
    output logic              busy,
    output logic              strb,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    state_t            state_q, state_d;
    logic [4:0]        cfg_k_q, cfg_k_d;
    logic [ADDR_W-1:0] cfg_size_q, cfg_size_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              load_done_q, load_done_d;
    logic              busy_q, busy_d;
    logic              strb_q, strb_d;
    logic              cfg_err_q, cfg_err_d;

    logic [3:0]        k_field;
    logic [ADDR_W-1:0] size_field;
    logic              cfg_bad;
    logic              last_pix;

    assign k_field    = sin[ADDR_W+3:ADDR_W];
    assign size_field = sin[ADDR_W-1:0];
    // A single cluster is meaningless for the core, so K field 1 is refused.
    assign cfg_bad    = (size_field == '0)
                     || ({1'b0, size_field} > (ADDR_W+1)'(MAX_PIX))
                     || (k_field == 4'h1);
    assign last_pix   = (cnt_q == cfg_size_q - ADDR_W'(1));

    always_comb begin
        state_d     = state_q;
        cfg_k_d     = cfg_k_q;
        cfg_size_d  = cfg_size_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_done_d = 1'b0;
        cfg_err_d   = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (sin_valid) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_k_d    = (k_field == 4'h0) ? 5'd16 : {1'b0, k_field};
                        cfg_size_d = size_field;
                        cfg_err_d  = 1'b0;
                        cnt_d      = '0;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                if (sin_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = sin;
                    // Counter parks on the final address rather than wrapping.
                    if (last_pix) begin
                        load_done_d = 1'b1;
                        state_d     = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            COMPUTE: begin
                if (compute_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        strb_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cfg_k_q     <= '0;
            cfg_size_q  <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_done_q <= 1'b0;
            busy_q      <= 1'b0;
            strb_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_k_q     <= cfg_k_d;
            cfg_size_q  <= cfg_size_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_done_q <= load_done_d;
            busy_q      <= busy_d;
            strb_q      <= strb_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg_k     = cfg_k_q;
    assign cfg_size  = cfg_size_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign load_done = load_done_q;
    assign busy      = busy_q;
    assign strb      = strb_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_kmean_rx_loader.sv
// Directed bench for kmean_rx_loader: config decode/reject, plain and gapped loads,
// completion handshake and reset abort, checked with immediate assertions.
module tb_kmean_rx_loader;

    logic        clk;
    logic        reset;
    logic [23:0] sin;
    logic        sin_valid;
    logic        compute_done;
    logic [4:0]  cfg_k;
    logic [6:0]  cfg_size;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        load_done;
    logic        busy;
    logic        strb;
    logic        cfg_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0]  wr_addr[$];
    logic [23:0] wr_data[$];
    int          ld_idx;
    int          ld_cnt;
    int          strb_cnt;

    kmean_rx_loader dut (
        .clk          (clk),
        .reset        (reset),
        .sin          (sin),
        .sin_valid    (sin_valid),
        .compute_done (compute_done),
        .cfg_k        (cfg_k),
        .cfg_size     (cfg_size),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .load_done    (load_done),
        .busy         (busy),
        .strb         (strb),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer-side observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (load_done === 1'b1) ld_idx = wr_addr.size() - 1;
        end
        if (load_done === 1'b1) ld_cnt++;
        if (strb === 1'b1) strb_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ld_idx = -1;
        ld_cnt = 0;
    endtask

    function automatic logic [23:0] pix(input logic [23:0] base, input int i);
        return base + 24'(i * 3);
    endfunction

    task automatic load_pixels(input int n, input logic [23:0] base);
        for (int i = 0; i < n; i++) begin
            sin       = pix(base, i);
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [23:0] base);
        int bad;
        bad = 0;
        chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < wr_addr.size() && i < n; i++) begin
            if (wr_addr[i] !== 7'(i) || wr_data[i] !== pix(base, i)) bad++;
        end
        chk({tag, "_wr_bad"}, 32'(bad), 32'd0);
        chk({tag, "_ld_idx"}, 32'(ld_idx), 32'(n - 1));
        chk({tag, "_ld_cnt"}, 32'(ld_cnt), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cfg_k"},     32'(cfg_k),     32'd0);
        chk({tag, "_cfg_size"},  32'(cfg_size),  32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_strb"},      32'(strb),      32'd0);
        chk({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
    endtask

    task automatic finish_compute();
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; sin = '0; sin_valid = 1'b0; compute_done = 1'b0;
        ld_idx = -1; ld_cnt = 0; strb_cnt = 0;
        tick();
        tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();

        // Basic load: K field 0 -> 16 clusters, size 100 (the maximum)
        sin = 24'h000064; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        chk("basic_cfg_k", 32'(cfg_k), 32'd16);
        chk("basic_cfg_size", 32'(cfg_size), 32'd100);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_cfg_err", 32'(cfg_err), 32'd0);
        chk("basic_no_cfg_write", 32'(mem_we), 32'd0);
        clear_log();
        for (int i = 0; i < 100; i++) begin
            sin = pix(24'hA00000, i); sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        chk("basic_last_we", 32'(mem_we), 32'd1);
        chk("basic_last_ld", 32'(load_done), 32'd1);
        chk("basic_last_addr", 32'(mem_addr), 32'd99);
        chk("basic_last_data", 32'(mem_wdata), 32'(pix(24'hA00000, 99)));
        tick();
        check_writes("basic", 100, 24'hA00000);
        chk("basic_busy_compute", 32'(busy), 32'd1);

        // Completion: 10 idle cycles, then compute_done
        strb_cnt = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("cmp_no_early_strb", 32'(strb_cnt), 32'd0);
        chk("cmp_busy_wait", 32'(busy), 32'd1);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        chk("cmp_strb", 32'(strb), 32'd1);
        chk("cmp_busy_done", 32'(busy), 32'd1);
        tick();
        chk("cmp_strb_off", 32'(strb), 32'd0);
        chk("cmp_busy_idle", 32'(busy), 32'd0);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        tick();
        tick();
        chk("cmp_strb_cnt", 32'(strb_cnt), 32'd1);
        chk("cmp_stray_busy", 32'(busy), 32'd0);
        chk("cmp_cfg_hold_k", 32'(cfg_k), 32'd16);
        chk("cmp_cfg_hold_size", 32'(cfg_size), 32'd100);

        // Gapped load: K=3, size=4, valid pattern 1,0,0,1,1,0,1
        sin = 24'h000184; sin_valid = 1'b1;
        tick();
        chk("gap_cfg_k", 32'(cfg_k), 32'd3);
        chk("gap_cfg_size", 32'(cfg_size), 32'd4);
        clear_log();
        begin
            logic [6:0] pat;
            int k;
            pat = 7'b1011001;
            k = 0;
            for (int s = 0; s < 7; s++) begin
                sin_valid = pat[s];
                sin = pat[s] ? pix(24'h3C0000, k) : 24'hDEAD00;
                if (pat[s]) k++;
                tick();
            end
        end
        sin_valid = 1'b0;
        tick();
        check_writes("gap", 4, 24'h3C0000);
        sin = 24'h123456; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        chk("gap_compute_we", 32'(mem_we), 32'd0);
        tick();
        chk("gap_compute_nwr", 32'(wr_addr.size()), 32'd4);
        chk("gap_compute_busy", 32'(busy), 32'd1);
        finish_compute();
        chk("gap_idle_busy", 32'(busy), 32'd0);

        // Rejected configs: size 0, size 101, K field 1
        clear_log();
        sin = 24'h000100; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        chk("rej0_err", 32'(cfg_err), 32'd1);
        chk("rej0_busy", 32'(busy), 32'd0);
        chk("rej0_k", 32'(cfg_k), 32'd3);
        chk("rej0_size", 32'(cfg_size), 32'd4);
        tick();
        sin = 24'h000165; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        chk("rej101_err", 32'(cfg_err), 32'd1);
        chk("rej101_busy", 32'(busy), 32'd0);
        chk("rej101_size", 32'(cfg_size), 32'd4);
        tick();
        sin = 24'h000085; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        chk("rejk1_err", 32'(cfg_err), 32'd1);
        chk("rejk1_busy", 32'(busy), 32'd0);
        chk("rejk1_k", 32'(cfg_k), 32'd3);
        tick();
        chk("rej_nwr", 32'(wr_addr.size()), 32'd0);

        // Accepted config with junk in the ignored upper bits: K=2, size=5
        sin = 24'hFFF905; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        chk("acc_err_clear", 32'(cfg_err), 32'd0);
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_k", 32'(cfg_k), 32'd2);
        chk("acc_size", 32'(cfg_size), 32'd5);
        load_pixels(5, 24'h055500);
        tick();
        check_writes("acc", 5, 24'h055500);
        finish_compute();

        // Reset mid-load after 50 of 100 pixels
        sin = 24'h000064; sin_valid = 1'b1;
        tick();
        load_pixels(50, 24'h700000);
        reset = 1'b1; sin = 24'h000203; sin_valid = 1'b1;
        tick();
        reset = 1'b0; sin_valid = 1'b0;
        check_all_zero("mid_rst");
        clear_log();
        tick();
        tick();
        chk("mid_rst_nwr", 32'(wr_addr.size()), 32'd0);
        chk("mid_rst_idle", 32'(busy), 32'd0);
        sin = 24'h000203; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        chk("post_rst_k", 32'(cfg_k), 32'd4);
        chk("post_rst_size", 32'(cfg_size), 32'd3);
        chk("post_rst_busy", 32'(busy), 32'd1);
        load_pixels(3, 24'h0ABC00);
        tick();
        check_writes("post_rst", 3, 24'h0ABC00);
        finish_compute();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
